// File: rtl/line_buffer_n_rows_if.sv
// Pixel stream bundle for line_buffer_n_rows: strobed pixel in, strobed column slice out.
interface line_buffer_n_rows_if #(
    parameter int DATA_W = 8,
    parameter int TAPS   = 5
);
    logic                     done_i;
    logic [DATA_W-1:0]        data_i;
    logic [TAPS*DATA_W-1:0]   data_o;
    logic                     done_o;
    logic                     progress_done_o;

    modport master (output done_i, data_i, input data_o, done_o, progress_done_o);
    modport slave  (input done_i, data_i, output data_o, done_o, progress_done_o);
endinterface

// File: rtl/line_buffer_n_rows.sv
// Raster line buffer presenting a TAPS-high column slice per accepted pixel,
// with frame-relative validity taken from the row counter.
module line_buffer_n_rows #(
    parameter int DATA_W    = 8,
    parameter int COLS      = 30,
    parameter int ROWS      = 30,
    parameter int TAPS      = 5,
    parameter int ZERO_FILL = 0
) (
    input logic              clk,
    input logic              rst,
    line_buffer_n_rows_if.slave bus
);
    localparam int COL_W = $clog2(COLS);
    localparam int ROW_W = $clog2(ROWS);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

    logic [DATA_W-1:0]      line_q [TAPS-1][COLS];
    logic [DATA_W-1:0]      line_d [TAPS-1][COLS];
    logic [COL_W-1:0]       col_q, col_d;
    logic [ROW_W-1:0]       row_q, row_d;
    logic [TAPS*DATA_W-1:0] data_o_q, data_o_d;
    logic                   done_o_q, done_o_d;
    logic                   prog_q, prog_d;

    always_comb begin
        line_d   = line_q;
        col_d    = col_q;
        row_d    = row_q;
        data_o_d = data_o_q;
        done_o_d = 1'b0;
        prog_d   = 1'b0;
        if (bus.done_i) begin
            // Each line's tail is the pixel one row above, same column, of its input.
            line_d[0][0] = bus.data_i;
            for (int k = 1; k < TAPS - 1; k++)
                line_d[k][0] = line_q[k-1][COLS-1];
            for (int k = 0; k < TAPS - 1; k++)
                for (int c = 1; c < COLS; c++)
                    line_d[k][c] = line_q[k][c-1];

            data_o_d[0 +: DATA_W] = bus.data_i;
            for (int k = 1; k < TAPS; k++)
                data_o_d[k*DATA_W +: DATA_W] =
                    (ZERO_FILL != 0 && int'(row_q) < k) ? '0 : line_q[k-1][COLS-1];

            done_o_d = (ZERO_FILL != 0) || (int'(row_q) >= TAPS - 1);
            prog_d   = (row_q == ROW_LAST) && (col_q == COL_LAST);

            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q    <= '0;
            row_q    <= '0;
            data_o_q <= '0;
            done_o_q <= 1'b0;
            prog_q   <= 1'b0;
        end else begin
            col_q    <= col_d;
            row_q    <= row_d;
            data_o_q <= data_o_d;
            done_o_q <= done_o_d;
            prog_q   <= prog_d;
        end
    end

    // Delay-line contents are never trusted across reset, so they carry no reset.
    always_ff @(posedge clk) begin
        line_q <= line_d;
    end

    assign bus.data_o          = data_o_q;
    assign bus.done_o          = done_o_q;
    assign bus.progress_done_o = prog_q;
endmodule

// File: tb/tb_line_buffer_n_rows.sv
// Scoreboard bench: a frame-array model predicts each beat at issue time,
// a negedge monitor pops and compares whenever a DUT presents done_o.
module tb_line_buffer_n_rows;
    localparam int ND = 5;
    localparam int TAPS_A [ND] = '{3, 3, 2, 9, 5};
    localparam int COLS_A [ND] = '{4, 4, 30, 2, 30};
    localparam int ROWS_A [ND] = '{4, 4, 3, 10, 5};
    localparam int ZF_A   [ND] = '{0, 1, 1, 0, 0};

    typedef struct packed {
        logic [71:0] data;
        logic        last;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       done_i;
    logic [7:0] data_i;
    logic       prev_di = 1'b0;

    logic [71:0] out_data [ND];
    logic        out_done [ND];
    logic        out_prog [ND];

    exp_t        sb [ND][$];
    logic [71:0] log0[$], logp0[$], log1[$];
    int          beats [ND];
    int          progs [ND];
    int          mrow [ND];
    int          mcol [ND];
    logic [7:0]  pix [ND][10][30];
    logic [23:0] tbl [8];
    int          n_checks = 0;
    int          n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) prev_di <= done_i;

    line_buffer_n_rows_if #(.DATA_W(8), .TAPS(3)) bus0 ();
    line_buffer_n_rows_if #(.DATA_W(8), .TAPS(3)) bus1 ();
    line_buffer_n_rows_if #(.DATA_W(8), .TAPS(2)) bus2 ();
    line_buffer_n_rows_if #(.DATA_W(8), .TAPS(9)) bus3 ();
    line_buffer_n_rows_if #(.DATA_W(8), .TAPS(5)) bus4 ();

    line_buffer_n_rows #(.DATA_W(8), .COLS(4), .ROWS(4), .TAPS(3), .ZERO_FILL(0))
        dut0 (.clk(clk), .rst(rst), .bus(bus0));
    line_buffer_n_rows #(.DATA_W(8), .COLS(4), .ROWS(4), .TAPS(3), .ZERO_FILL(1))
        dut1 (.clk(clk), .rst(rst), .bus(bus1));
    line_buffer_n_rows #(.DATA_W(8), .COLS(30), .ROWS(3), .TAPS(2), .ZERO_FILL(1))
        dut2 (.clk(clk), .rst(rst), .bus(bus2));
    line_buffer_n_rows #(.DATA_W(8), .COLS(2), .ROWS(10), .TAPS(9), .ZERO_FILL(0))
        dut3 (.clk(clk), .rst(rst), .bus(bus3));
    line_buffer_n_rows #(.DATA_W(8), .COLS(30), .ROWS(5), .TAPS(5), .ZERO_FILL(0))
        dut4 (.clk(clk), .rst(rst), .bus(bus4));

    assign bus0.done_i = done_i;  assign bus0.data_i = data_i;
    assign bus1.done_i = done_i;  assign bus1.data_i = data_i;
    assign bus2.done_i = done_i;  assign bus2.data_i = data_i;
    assign bus3.done_i = done_i;  assign bus3.data_i = data_i;
    assign bus4.done_i = done_i;  assign bus4.data_i = data_i;

    assign out_data[0] = 72'(bus0.data_o);
    assign out_data[1] = 72'(bus1.data_o);
    assign out_data[2] = 72'(bus2.data_o);
    assign out_data[3] = 72'(bus3.data_o);
    assign out_data[4] = 72'(bus4.data_o);
    assign out_done[0] = bus0.done_o;  assign out_prog[0] = bus0.progress_done_o;
    assign out_done[1] = bus1.done_o;  assign out_prog[1] = bus1.progress_done_o;
    assign out_done[2] = bus2.done_o;  assign out_prog[2] = bus2.progress_done_o;
    assign out_done[3] = bus3.done_o;  assign out_prog[3] = bus3.progress_done_o;
    assign out_done[4] = bus4.done_o;  assign out_prog[4] = bus4.progress_done_o;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference: keep every pixel of the current frame by (row, col) and read the column back.
    task automatic model_pixel(input logic [7:0] d);
        exp_t e;
        for (int i = 0; i < ND; i++) begin
            pix[i][mrow[i]][mcol[i]] = d;
            if (ZF_A[i] != 0 || mrow[i] >= TAPS_A[i] - 1) begin
                e.data = '0;
                for (int k = 0; k < TAPS_A[i]; k++)
                    if (mrow[i] >= k) e.data[k*8 +: 8] = pix[i][mrow[i]-k][mcol[i]];
                e.last = (mrow[i] == ROWS_A[i] - 1) && (mcol[i] == COLS_A[i] - 1);
                sb[i].push_back(e);
            end
            if (mcol[i] == COLS_A[i] - 1) begin
                mcol[i] = 0;
                mrow[i] = (mrow[i] == ROWS_A[i] - 1) ? 0 : mrow[i] + 1;
            end else begin
                mcol[i] = mcol[i] + 1;
            end
        end
    endtask

    task automatic px(input logic v, input logic [7:0] d);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        done_i = v;
        data_i = d;
        if (v) model_pixel(d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) px(1'b0, 8'h5A);
    endtask

    task automatic clear_logs();
        log0.delete();
        logp0.delete();
        log1.delete();
        for (int i = 0; i < ND; i++) begin
            beats[i] = 0;
            progs[i] = 0;
        end
    endtask

    task automatic apply_reset(input int n);
        @(posedge clk);
        #1;
        rst    = 1'b1;
        done_i = 1'b1;
        data_i = 8'hEE;
        for (int i = 0; i < ND; i++) begin
            mrow[i] = 0;
            mcol[i] = 0;
        end
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            @(negedge clk);
            chk("reset_data_o", out_data[0], 72'h0);
            chk("reset_done_o", 72'(out_done[0]), 72'h0);
            chk("reset_progress", 72'(out_prog[0]), 72'h0);
        end
    endtask

    task automatic check_table(input string tag);
        chk({tag, "_beat_count"}, 72'(log0.size()), 72'd8);
        for (int j = 0; j < 8; j++)
            if (j < log0.size()) chk($sformatf("%s_beat%0d", tag, j), log0[j], 72'(tbl[j]));
    endtask

    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < ND; i++) begin
            if (out_done[i]) begin
                chk($sformatf("no_beat_after_gap_dut%0d", i), 72'(prev_di), 72'd1);
                if (sb[i].size() == 0) begin
                    chk($sformatf("unexpected_beat_dut%0d", i), 72'd1, 72'd0);
                end else begin
                    e = sb[i].pop_front();
                    chk($sformatf("beat_data_dut%0d", i), out_data[i], e.data);
                    chk($sformatf("beat_progress_dut%0d", i), 72'(out_prog[i]), 72'(e.last));
                end
                beats[i]++;
                if (out_prog[i]) progs[i]++;
                if (i == 0) log0.push_back(out_data[0]);
                if (i == 0 && out_prog[0]) logp0.push_back(out_data[0]);
                if (i == 1) log1.push_back(out_data[1]);
            end else if (out_prog[i]) begin
                chk($sformatf("stray_progress_dut%0d", i), 72'd1, 72'd0);
            end
        end
    end

    initial begin
        logic [7:0] v;
        tbl[0] = 24'h001020; tbl[1] = 24'h011121; tbl[2] = 24'h021222; tbl[3] = 24'h031323;
        tbl[4] = 24'h102030; tbl[5] = 24'h112131; tbl[6] = 24'h122232; tbl[7] = 24'h132333;
        rst = 1'b1;
        done_i = 1'b0;
        data_i = 8'h00;
        apply_reset(3);
        clear_logs();

        // Single frame, back-to-back, first pixel right after reset release.
        for (int p = 0; p < 16; p++) px(1'b1, 8'((p / 4) * 16 + p % 4));
        idle(3);
        check_table("frame1");
        chk("frame1_progress_count", 72'(progs[0]), 72'd1);
        if (logp0.size() > 0) chk("frame1_progress_data", logp0[0], 72'h132333);
        chk("zf_beat_count", 72'(beats[1]), 72'd16);
        if (log1.size() == 16) begin
            chk("zf_pixel00", log1[0], 72'h000000);
            chk("zf_pixel11", log1[5], 72'h000111);
        end

        // Same frame with random gaps.
        clear_logs();
        for (int p = 0; p < 16; p++) begin
            repeat ($urandom_range(0, 2)) px(1'b0, 8'($urandom));
            px(1'b1, 8'((p / 4) * 16 + p % 4));
        end
        idle(3);
        check_table("gaps");
        chk("gaps_progress_count", 72'(progs[0]), 72'd1);

        // Two frames back-to-back, second offset by 0x80.
        clear_logs();
        for (int p = 0; p < 32; p++) begin
            v = 8'(((p % 16) / 4) * 16 + p % 4 + ((p >= 16) ? 8'h80 : 8'h00));
            px(1'b1, v);
        end
        idle(3);
        chk("two_frames_beat_count", 72'(log0.size()), 72'd16);
        if (log0.size() > 8) chk("frame2_first_beat", log0[8], 72'h8090A0);
        chk("two_frames_progress_count", 72'(progs[0]), 72'd2);

        // Reset after 7 pixels, then a fresh frame.
        for (int p = 0; p < 7; p++) px(1'b1, 8'hC0 + 8'(p));
        apply_reset(3);
        clear_logs();
        for (int p = 0; p < 16; p++) px(1'b1, 8'((p / 4) * 16 + p % 4));
        idle(3);
        check_table("post_reset");
        if (logp0.size() == 1) chk("post_reset_progress_data", logp0[0], 72'h132333);
        chk("post_reset_progress_count", 72'(progs[0]), 72'd1);

        // Long random stream to exercise the wide/deep configurations.
        clear_logs();
        for (int p = 0; p < 330; p++) begin
            if ($urandom_range(0, 3) == 0) px(1'b0, 8'($urandom));
            px(1'b1, 8'($urandom));
        end
        idle(3);
        chk("sweep_progress_dut2", 72'(progs[2]), 72'd3);
        chk("sweep_progress_dut3", 72'(progs[3]), 72'd17);
        chk("sweep_progress_dut4", 72'(progs[4]), 72'd2);

        for (int i = 0; i < ND; i++)
            chk($sformatf("scoreboard_drained_dut%0d", i), 72'(sb[i].size()), 72'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
